counter_sequence_controller: RTL and testbench

COUNTER_SEQUENCE_CONTROLLER -- requirements
Module: counter_sequence_controller

---
 rtl/counter_sequence_controller_if.sv | 23 ++
 rtl/counter_sequence_controller.sv | 112 +++++++++++
 tb/tb_counter_sequence_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/counter_sequence_controller_if.sv
// Run-request and status bundle between a sequencer client and counter_sequence_controller.
// master drives the run request; slave (the controller) returns the counter/FSM status.
interface counter_sequence_controller_if;
    logic       start;
    logic [2:0] target;
    logic       bounce;
    logic       abort;
    logic [2:0] count;
    logic       mode;
    logic       busy;
    logic       done;
    logic [1:0] state;

    modport master (
        output start, target, bounce, abort,
        input  count, mode, busy, done, state
    );

    modport slave (
        input  start, target, bounce, abort,
        output count, mode, busy, done, state
    );
endinterface

// File: rtl/counter_sequence_controller.sv
// Steps a 3-bit counter up/down toward a latched target (optionally up-then-down-to-0).
// Latency: |target-count|+1 edges to done (bounce: up+down+1); abort/reset end a run silently.
// No backpressure: start is only sampled in IDLE, all outputs are registered.
module counter_sequence_controller (
    input  logic                          clk,
    input  logic                          rst,
    counter_sequence_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_count;
    logic [2:0] w_next_count;
    logic [2:0] r_target;
    logic       r_bounce;
    logic       r_mode;
    logic       r_busy;
    logic       r_done;
    logic [2:0] w_inc;
    logic [2:0] w_dec;
    logic       w_accept;

    assign w_inc    = r_count + 3'd1;
    assign w_dec    = r_count - 3'd1;
    assign w_accept = (r_state == S_IDLE) && bus.start;

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.bounce) begin
                        if (bus.target > r_count)
                            w_next_state = S_UP;
                        else if (bus.target < r_count)
                            w_next_state = S_DOWN;
                        else
                            w_next_state = S_DONE;
                    end else begin
                        if (bus.target != r_count)
                            w_next_state = S_UP;
                        else if (r_count != 3'd0)
                            w_next_state = S_DOWN;
                        else
                            w_next_state = S_DONE;
                    end
                end
            end
            S_UP: begin
                // Abort wins over the step: counter is frozen where it stands.
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_count = w_inc;
                    if (w_inc == r_target)
                        w_next_state = (!r_bounce || r_target == 3'd0) ? S_DONE : S_DOWN;
                end
            end
            S_DOWN: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_count = w_dec;
                    if (r_bounce ? (w_dec == 3'd0) : (w_dec == r_target))
                        w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_count  <= 3'd0;
            r_target <= 3'd0;
            r_bounce <= 1'b0;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_accept) begin
                r_target <= bus.target;
                r_bounce <= bus.bounce;
            end
            // Status flags track the state being entered so they line up with r_state.
            r_mode <= (w_next_state == S_UP);
            r_busy <= (w_next_state == S_UP) || (w_next_state == S_DOWN);
            r_done <= (w_next_state == S_DONE);
        end
    end

    assign bus.count = r_count;
    assign bus.mode  = r_mode;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.state = r_state;
endmodule

// File: tb/tb_counter_sequence_controller.sv
// Directed bench for counter_sequence_controller with hand-computed count/state sequences.
module tb_counter_sequence_controller;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    counter_sequence_controller_if bus_if ();

    counter_sequence_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full observable status for a given state code; flags follow from the state.
    task automatic chk_all(input string tag, input int st, input int cnt);
        chk({tag, ".state"}, int'(bus_if.state), st);
        chk({tag, ".count"}, int'(bus_if.count), cnt);
        chk({tag, ".mode"},  int'(bus_if.mode),  (st == 1) ? 1 : 0);
        chk({tag, ".busy"},  int'(bus_if.busy),  (st == 1 || st == 2) ? 1 : 0);
        chk({tag, ".done"},  int'(bus_if.done),  (st == 3) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [2:0] tgt, input logic bnc);
        bus_if.start  = 1'b1;
        bus_if.target = tgt;
        bus_if.bounce = bnc;
        step();
        bus_if.start  = 1'b0;
    endtask

    int exp_cnt [7];
    int exp_st  [7];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst           = 1'b0;
        bus_if.start  = 1'b1;
        bus_if.target = 3'd3;
        bus_if.bounce = 1'b0;
        bus_if.abort  = 1'b0;
        @(negedge clk);
        step();
        chk_all("reset", 0, 0);

        // First start accepted on the very first edge with rst released.
        rst = 1'b1;
        launch(3'd5, 1'b0);
        chk_all("up5_start", 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_all($sformatf("up5_%0d", i), (i == 5) ? 3 : 1, i);
        end
        step();
        chk_all("up5_idle", 0, 5);

        launch(3'd2, 1'b0);
        chk_all("dn2_start", 2, 5);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_all($sformatf("dn2_%0d", i), (i == 3) ? 3 : 2, 5 - i);
        end
        step();
        chk_all("dn2_idle", 0, 2);

        // Bounce with wrap 7->0; inputs scrambled mid-run must be ignored.
        exp_cnt = '{3, 4, 5, 6, 7, 0, 1};
        exp_st  = '{1, 1, 1, 1, 1, 1, 2};
        launch(3'd1, 1'b1);
        chk_all("bnc_start", 1, 2);
        bus_if.target = 3'd7;
        bus_if.bounce = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_if.start = (i == 2) ? 1'b1 : 1'b0;
            step();
            chk_all($sformatf("bnc_up%0d", i), exp_st[i], exp_cnt[i]);
        end
        bus_if.start = 1'b0;
        step();
        chk_all("bnc_done", 3, 0);
        step();
        chk_all("bnc_idle", 0, 0);

        // Abort at count 3 with start pulses during the run.
        launch(3'd6, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            bus_if.start  = 1'b1;
            bus_if.target = 3'd0;
            step();
            chk_all($sformatf("ab_up%0d", i), 1, i);
        end
        bus_if.start = 1'b0;
        bus_if.abort = 1'b1;
        step();
        chk_all("ab_idle", 0, 3);
        step();
        chk_all("ab_ignored_idle", 0, 3);
        bus_if.abort = 1'b0;

        // Reset mid-DOWN with start held.
        launch(3'd0, 1'b0);
        chk_all("rd_start", 2, 3);
        step();
        chk_all("rd_dn", 2, 2);
        rst          = 1'b0;
        bus_if.start = 1'b1;
        step();
        chk_all("rd_reset", 0, 0);
        rst          = 1'b1;
        bus_if.start = 1'b0;
        step();
        chk_all("rd_after", 0, 0);

        // Reach count 4, then equal-target start goes straight to DONE.
        launch(3'd4, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk_all("eq_pre", 3, 4);
        step();
        launch(3'd4, 1'b0);
        chk_all("eq_done", 3, 4);
        step();
        chk_all("eq_idle", 0, 4);

        // Bounce with target==count!=0 heads straight down to 0.
        launch(3'd4, 1'b1);
        chk_all("bd_start", 2, 4);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_all($sformatf("bd_%0d", i), (i == 4) ? 3 : 2, 4 - i);
        end
        step();

        // Bounce target==count==0 -> DONE; abort in IDLE and DONE has no effect.
        bus_if.abort = 1'b1;
        launch(3'd0, 1'b1);
        chk_all("b0_done", 3, 0);
        step();
        chk_all("b0_idle", 0, 0);
        bus_if.abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
